// File: rtl/switch_cfg_pkg.sv
// Shared definitions for the switch-matrix configuration loader:
// entry layout, source-side encodings, FSM states and the CRC-8 step.
package switch_cfg_pkg;

    localparam int ENTRY_W = 6;

    localparam logic [2:0] SRC_OPEN   = 3'd0;
    localparam logic [2:0] SRC_TOP    = 3'd1;
    localparam logic [2:0] SRC_RIGHT  = 3'd2;
    localparam logic [2:0] SRC_BOTTOM = 3'd3;
    localparam logic [2:0] SRC_LEFT   = 3'd4;

    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOAD,
        ST_CHECK,
        ST_COMMIT
    } state_e;

    // One serial CRC-8 step, MSB-first, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/switch_cfg_crc8.sv
// Serial CRC-8 accumulator, one bit per enabled cycle.
// Only instantiated when CFG_CRC_EN is defined.
module switch_cfg_crc8
    import switch_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Clear has priority over accumulating a bit.
    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = crc8_step(crc_q, bit_i);
        end
    end

    // CRC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/switch_cfg_loader.sv
// Serial loader for the switch-matrix configuration word.
// Frame: sync word, then one 6-bit entry per pin (MSB first), optionally
// followed by an 8-bit CRC when CFG_CRC_EN is defined.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no frame in progress, waiting for the first bit
// ST_SYNC   | sliding the sync shifter until it holds SYNC_WORD
// ST_LOAD   | shifting payload (and CRC) bits into the shadow register
// ST_CHECK  | one-cycle legality check of the complete shadow register
// ST_COMMIT | copy shadow into cfg_word
module switch_cfg_loader
    import switch_cfg_pkg::*;
#(
    parameter int         N_TB      = 5,
    parameter int         N_LR      = 4,
    parameter logic [7:0] SYNC_WORD = 8'hA5
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    input  logic                                   in_bit,
    output logic                                   in_ready,
    output logic [ENTRY_W*(2*N_TB+2*N_LR)-1:0]     cfg_word,
    output logic                                   cfg_done,
    output logic                                   cfg_err,
    output logic                                   busy
);

    localparam int N_ENT = 2*N_TB + 2*N_LR;
    localparam int CFG_W = ENTRY_W*N_ENT;
`ifdef CFG_CRC_EN
    localparam int CRC_BITS = 8;
`else
    localparam int CRC_BITS = 0;
`endif
    localparam int FRAME_BITS = CFG_W + CRC_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    state_e               state_q, state_d;
    logic [7:0]           sync_q, sync_d, sync_shift;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           sub_q, sub_d;
    logic [ENTRY_W-2:0]   ent_q, ent_d;
    logic [CFG_W-1:0]     shadow_q, shadow_d;
    logic [CFG_W-1:0]     cfg_word_q;
    logic                 done_q, err_q;
    logic                 accept, in_payload, entry_bad, frame_bad;

    assign accept     = in_valid && in_ready;
    assign in_payload = cnt_q < CNT_W'(CFG_W);
    assign sync_shift = {sync_q[6:0], in_bit};

`ifdef CFG_CRC_EN
    logic [7:0] crc_rx_q, crc_rx_d, crc_calc;

    switch_cfg_crc8 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q == ST_IDLE),
        .en_i  (accept && (state_q == ST_LOAD) && in_payload),
        .bit_i (in_bit),
        .crc_o (crc_calc)
    );
`endif

    // Legality of every entry: known source, index within that side's width.
    always_comb begin
        entry_bad = 1'b0;
        for (int k = 0; k < N_ENT; k++) begin
            case (shadow_q[ENTRY_W*k +: 3])
                SRC_OPEN: ;
                SRC_TOP, SRC_BOTTOM: begin
                    if (int'(shadow_q[ENTRY_W*k+3 +: 3]) >= N_TB) entry_bad = 1'b1;
                end
                SRC_LEFT, SRC_RIGHT: begin
                    if (int'(shadow_q[ENTRY_W*k+3 +: 3]) >= N_LR) entry_bad = 1'b1;
                end
                default: entry_bad = 1'b1;
            endcase
        end
    end

`ifdef CFG_CRC_EN
    assign frame_bad = entry_bad || (crc_rx_q != crc_calc);
`else
    assign frame_bad = entry_bad;
`endif

    // Next-state and datapath updates; all state holds when no bit transfers.
    always_comb begin
        state_d  = state_q;
        sync_d   = sync_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        ent_d    = ent_q;
        shadow_d = shadow_q;
`ifdef CFG_CRC_EN
        crc_rx_d = crc_rx_q;
`endif
        case (state_q)
            ST_IDLE, ST_SYNC: begin
                if (accept) begin
                    sync_d  = sync_shift;
                    state_d = (sync_shift == SYNC_WORD) ? ST_LOAD : ST_SYNC;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (in_payload) begin
                        // Entries are assembled whole and pushed in from the top,
                        // so the first entry received lands at bits [5:0].
                        if (sub_q == 3'd5) begin
                            shadow_d = {ent_q, in_bit, shadow_q[CFG_W-1:ENTRY_W]};
                            sub_d    = '0;
                        end else begin
                            ent_d = {ent_q[ENTRY_W-3:0], in_bit};
                            sub_d = sub_q + 3'd1;
                        end
                    end
`ifdef CFG_CRC_EN
                    else begin
                        crc_rx_d = {crc_rx_q[6:0], in_bit};
                    end
`endif
                    if (cnt_q == CNT_W'(FRAME_BITS-1)) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = frame_bad ? ST_IDLE : ST_COMMIT;
                sync_d  = '0;
                cnt_d   = '0;
                sub_d   = '0;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and frame-assembly registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sync_q   <= '0;
            cnt_q    <= '0;
            sub_q    <= '0;
            ent_q    <= '0;
            shadow_q <= '0;
`ifdef CFG_CRC_EN
            crc_rx_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            ent_q    <= ent_d;
            shadow_q <= shadow_d;
`ifdef CFG_CRC_EN
            crc_rx_q <= crc_rx_d;
`endif
        end
    end

    // Committed word and result pulses; done rises together with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_word_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == ST_COMMIT) cfg_word_q <= shadow_q;
            done_q <= (state_q == ST_COMMIT);
            err_q  <= (state_q == ST_CHECK) && frame_bad;
        end
    end

    assign cfg_word = cfg_word_q;
    assign cfg_done = done_q;
    assign cfg_err  = err_q;
    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_SYNC) || (state_q == ST_LOAD);
    assign busy     = (state_q != ST_IDLE);

endmodule
